imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_if.sv | 55 +++++
 rtl/imem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter and its neighbours.
// Members:
//   fetch_*  : core instruction fetch request/grant and registered response
//   ld_*     : program loader write port and load-complete pulse
//   prog_req_i, core_hold_o : reprogramming request and core hold
//   mem_*    : single-port instruction memory (asynchronous read)
// Modports: slave = the arbiter, master = the surrounding system.
interface imem_arbiter_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          fetch_req_i;
  logic [31:0]   fetch_addr_i;
  logic          fetch_gnt_o;
  logic          fetch_valid_o;
  logic [31:0]   fetch_instr_o;
  logic          fetch_err_o;

  logic          ld_valid_i;
  logic [31:0]   ld_addr_i;
  logic [31:0]   ld_data_i;
  logic          ld_ready_o;
  logic          ld_done_i;

  logic          prog_req_i;
  logic          core_hold_o;

  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i,
    output fetch_gnt_o, fetch_valid_o, fetch_instr_o, fetch_err_o,
    input  ld_valid_i, ld_addr_i, ld_data_i, ld_done_i,
    output ld_ready_o,
    input  prog_req_i,
    output core_hold_o,
    output mem_addr_o, mem_we_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output fetch_req_i, fetch_addr_i,
    input  fetch_gnt_o, fetch_valid_o, fetch_instr_o, fetch_err_o,
    output ld_valid_i, ld_addr_i, ld_data_i, ld_done_i,
    input  ld_ready_o,
    output prog_req_i,
    input  core_hold_o,
    input  mem_addr_o, mem_we_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: shares one single-port instruction memory
// between the core fetch path and a program loader.
//   BOOT  : core held, loader owns the memory until ld_done_i.
//   RUN   : fetch and loader arbitrated, loader first, with a starvation
//           counter forcing a fetch grant after BURST_MAX loader wins.
//   DRAIN : core held, no new fetches; returns to BOOT for reprogramming.
// Ports:
//   CLK    : clock, all state on posedge
//   nRESET : asynchronous active-low reset
//   bus    : imem_arbiter_if.slave (fetch, loader, control, memory port)
// Fetch responses are registered (1-cycle latency); bad fetch addresses
// return a NOP with fetch_err_o and never touch the memory. Bad loader
// addresses are accepted but the write is dropped.
module imem_arbiter #(
  parameter int DEPTH     = 64,
  parameter int BURST_MAX = 4
) (
  input  logic         CLK,
  input  logic         nRESET,
  imem_arbiter_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] ADDR_LIM  = 32'(4 * DEPTH);
  localparam logic [3:0]  BURST_LIM = 4'(BURST_MAX);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt, starve_nxt;

  logic        fetch_ok;
  logic        ld_ok;
  logic        gnt_f;
  logic        gnt_l;

  logic        hold_q;
  logic        valid_q;
  logic        err_q;
  logic [31:0] instr_q;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;

  // Address legality: word aligned and inside the memory.
  always_comb begin
    fetch_ok = (bus.fetch_addr_i[1:0] == 2'b00) && (bus.fetch_addr_i < ADDR_LIM);
    ld_ok    = (bus.ld_addr_i[1:0]    == 2'b00) && (bus.ld_addr_i    < ADDR_LIM);
  end

  // Next state, grants and starvation counter.
  always_comb begin
    state_nxt  = state;
    starve_nxt = '0;
    gnt_f      = 1'b0;
    gnt_l      = 1'b0;

    unique case (state)
      BOOT: begin
        gnt_l = bus.ld_valid_i;
        if (bus.ld_done_i && !bus.prog_req_i) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        // Loader wins unless the fetch side has waited BURST_MAX grants.
        if (bus.fetch_req_i && (!bus.ld_valid_i || (starve_cnt >= BURST_LIM))) begin
          gnt_f = 1'b1;
        end else begin
          gnt_l = bus.ld_valid_i;
        end
        // Counts only loader wins over a waiting fetch; any fetch grant or
        // idle fetch cycle clears it.
        if (gnt_l && bus.fetch_req_i) begin
          starve_nxt = starve_cnt + 4'd1;
        end
        if (bus.prog_req_i && !bus.ld_done_i) begin
          state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        // A fetch granted alongside prog_req_i responds in the first DRAIN
        // cycle, so no response can still be pending at the next edge.
        state_nxt = BOOT;
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // Memory port: loader write, fetch read, or parked at word 0.
  always_comb begin
    mem_we    = gnt_l && ld_ok;
    mem_wdata = '0;
    mem_addr  = '0;
    if (mem_we) begin
      mem_addr  = bus.ld_addr_i[AW+1:2];
      mem_wdata = bus.ld_data_i;
    end else if (gnt_f && fetch_ok) begin
      mem_addr  = bus.fetch_addr_i[AW+1:2];
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state      <= BOOT;
      starve_cnt <= '0;
      hold_q     <= 1'b1;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      instr_q    <= NOP;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      hold_q     <= (state_nxt != RUN);
      valid_q    <= gnt_f;
      err_q      <= gnt_f && !fetch_ok;
      if (gnt_f) begin
        instr_q  <= fetch_ok ? bus.mem_rdata_i : NOP;
      end
    end
  end

  always_comb begin
    bus.fetch_gnt_o   = gnt_f;
    bus.fetch_valid_o = valid_q;
    bus.fetch_err_o   = err_q;
    bus.fetch_instr_o = instr_q;
    bus.ld_ready_o    = gnt_l;
    bus.core_hold_o   = hold_q;
    bus.mem_addr_o    = mem_addr;
    bus.mem_we_o      = mem_we;
    bus.mem_wdata_o   = mem_wdata;
  end

  // Structural invariants of the arbiter.
  a_one_grant : assert property (@(posedge CLK) disable iff (!nRESET)
    !(gnt_f && gnt_l));
  a_we_needs_gnt : assert property (@(posedge CLK) disable iff (!nRESET)
    mem_we |-> gnt_l);
  a_cnt_bound : assert property (@(posedge CLK) disable iff (!nRESET)
    starve_cnt <= BURST_LIM);

endmodule
